// File: rtl/usart_tx_arbiter.sv
// Round-robin arbiter sharing the usart TX FIFO write port among N_REQ byte producers.
// Optional packet lock (grant held until req_last or MAX_BURST bytes) under USART_ARB_PKT_LOCK_EN.
module usart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]       tx_data,
  output logic                        tx_write_en,
  input  logic                        tx_full,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic                        busy
);

  localparam int IDW = $clog2(N_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [IDW-1:0]        rr_ptr;
  logic [IDW-1:0]        pick_id;
  logic                  pick_found;
  logic                  grant_ready;
  logic                  accept;
  logic                  release_grant;
  logic                  start_grant;
  logic [DATA_WIDTH-1:0] grant_data;

  // First valid requester after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!pick_found && req_valid[IDW'((int'(rr_ptr) + k) % N_REQ)]) begin
        pick_found = 1'b1;
        pick_id    = IDW'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == IDW'(i)) grant_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Handshake: a byte transfers on a rising edge where req_valid[i] && req_ready[i];
  // ready never depends on valid, and is masked during a write so the FIFO full flag settles first.
  assign grant_ready = (state == GRANT) && !tx_full && !tx_write_en;
  assign accept      = grant_ready && req_valid[grant_id];
  assign start_grant = (state == IDLE) && (state_nxt == GRANT);

`ifdef USART_ARB_PKT_LOCK_EN
  localparam int BCW = $clog2(MAX_BURST + 1);

  logic [BCW-1:0] burst_cnt;

  assign release_grant = accept && (req_last[grant_id] || (burst_cnt == BCW'(MAX_BURST - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if (start_grant) begin
      burst_cnt <= '0;
    end else if (accept) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign release_grant = accept;
  assign unused_cfg    = ^{req_last, (MAX_BURST > 0)};
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; arbitration is frozen while the FIFO is full
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found && !tx_full) state_nxt = GRANT;
      GRANT:   if (release_grant) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready           = '0;
    req_ready[grant_id] = grant_ready;
    busy                = (state == GRANT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id    <= '0;
      rr_ptr      <= IDW'(N_REQ - 1);
      tx_data     <= '0;
      tx_write_en <= 1'b0;
    end else begin
      tx_write_en <= accept;
      if (accept) tx_data <= grant_data;
      if (start_grant) grant_id <= pick_id;
      if (release_grant) rr_ptr <= grant_id;
    end
  end

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// Directed bench for usart_tx_arbiter; lock-mode scenarios build when USART_ARB_PKT_LOCK_EN is defined.
module tb_usart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_write_en;
  logic        tx_full;
  logic [1:0]  grant_id;
  logic        busy;

  int checks;
  int errors;

  logic [8:0] src_q [4][$];
  logic [7:0] wr_q[$];
  logic [7:0] exp_q[$];

  usart_tx_arbiter #(
    .N_REQ      (4),
    .DATA_WIDTH (8),
    .MAX_BURST  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_write_en (tx_write_en),
    .tx_full     (tx_full),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO model: captures the byte at the edge that ends the write cycle
  initial begin : fifo_capture
    forever begin
      @(posedge clk);
      if (tx_write_en === 1'b1) wr_q.push_back(tx_data);
    end
  end

  // Producers: each requester presents the head of its queue and pops it after a handshake
  initial begin : producers
    logic [3:0] hs;
    logic [8:0] h;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(posedge clk);
      hs = req_valid & req_ready;
      #2;
      for (int i = 0; i < 4; i++) begin
        if (hs[i] && src_q[i].size() > 0) h = src_q[i].pop_front();
        if (src_q[i].size() > 0) begin
          h                  = src_q[i][0];
          req_valid[i]       = 1'b1;
          req_data[i*8 +: 8] = h[7:0];
          req_last[i]        = h[8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    tx_full = 1'b0;
    for (int i = 0; i < 4; i++) src_q[i].delete();
    tick(2);
    wr_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (wr_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    checks++;
    assert (wr_q.size() >= n) else begin
      errors++;
      $error("FAIL %s_timeout observed=%0d expected=%0d writes", tag, wr_q.size(), n);
    end
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < wr_q.size()) chk($sformatf("%s_byte%0d", tag, i), wr_q[i], exp_q[i]);
    end
    wr_q.delete();
    exp_q.delete();
  endtask

  initial begin : stimulus
    int c;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    tx_full = 1'b0;

    // Reset values
    tick(2);
    chk("rst_busy", busy, 0);
    chk("rst_wen", tx_write_en, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_ready", req_ready, 0);

    // Single requester, one byte
    do_reset();
    src_q[0].push_back(9'h0A5);
    tick(1);
    chk("single_idle_busy", busy, 0);
    chk("single_idle_ready", req_ready, 0);
    tick(1);
    chk("single_grant_busy", busy, 1);
    chk("single_grant_id", grant_id, 0);
    chk("single_ready", req_ready, 4'b0001);
    tick(1);
    chk("single_wen", tx_write_en, 1);
    chk("single_data", tx_data, 8'hA5);
    chk("single_busy_drop", busy, 0);
    tick(1);
    chk("single_wen_pulse", tx_write_en, 0);
    exp_q.push_back(8'hA5);
    check_stream("single");

    // FIFO full blocks all accepts and writes
    do_reset();
    tx_full = 1'b1;
    src_q[2].push_back(9'h077);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("full_ready", req_ready, 0);
      chk("full_wen", tx_write_en, 0);
    end
    tx_full = 1'b0;
    wait_writes("full", 1, 20);
    tick(5);
    exp_q.push_back(8'h77);
    check_stream("full");

`ifdef USART_ARB_PKT_LOCK_EN
    // Packet held until req_last
    do_reset();
    src_q[1].push_back(9'h011);
    src_q[1].push_back(9'h022);
    src_q[1].push_back(9'h133);
    src_q[2].push_back(9'h199);
    wait_writes("pkt", 4, 40);
    tick(4);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h99);
    check_stream("pkt");

    // MAX_BURST=4 forces release mid-packet
    do_reset();
    for (int i = 1; i <= 6; i++) src_q[0].push_back(9'(i));
    src_q[3].push_back(9'h1D0);
    wait_writes("burst", 7, 60);
    tick(4);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'hD0);
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h06);
    check_stream("burst");
`else
    // Per-byte round robin with all requesters busy
    do_reset();
    for (int r = 0; r < 2; r++) begin
      src_q[0].push_back(9'h010);
      src_q[1].push_back(9'h020);
      src_q[2].push_back(9'h030);
      src_q[3].push_back(9'h040);
    end
    wait_writes("rr", 8, 60);
    tick(4);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(8'h10);
      exp_q.push_back(8'h20);
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h40);
    end
    check_stream("rr");

    // req_last does not hold the grant
    do_reset();
    src_q[1].push_back(9'h011);
    src_q[1].push_back(9'h022);
    src_q[1].push_back(9'h133);
    src_q[2].push_back(9'h199);
    wait_writes("nolock", 4, 40);
    tick(4);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h99);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    check_stream("nolock");
`endif

    // Reset asserted during a write cycle
    do_reset();
    src_q[0].push_back(9'h0A1);
    src_q[0].push_back(9'h0A2);
    src_q[0].push_back(9'h1A3);
    c = 0;
    while (tx_write_en !== 1'b1 && c < 20) begin
      tick(1);
      c++;
    end
    chk("midrst_wen_seen", tx_write_en, 1);
    chk("midrst_data_seen", tx_data, 8'hA1);
    src_q[2].push_back(9'h1B2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_wen", tx_write_en, 0);
    chk("midrst_data", tx_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", req_ready, 0);
    chk("midrst_grant", grant_id, 0);
    tick(3);
    wr_q.delete();
    rst_n = 1'b1;
    c = 0;
    while (busy !== 1'b1 && c < 10) begin
      tick(1);
      c++;
    end
    chk("midrst_first_busy", busy, 1);
    chk("midrst_first_grant", grant_id, 0);
    wait_writes("midrst", 1, 20);
    if (wr_q.size() > 0) chk("midrst_first_byte", wr_q[0], 8'hA2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usart_tx_arbiter.md
# usart_tx_arbiter

Round-robin arbiter that shares the single TX write port of the `usart` block between `N_REQ` independent byte producers. Each requester offers bytes on a valid/ready handshake. The arbiter grants one requester at a time, forwards accepted bytes as registered `tx_data`/`tx_write_en` pulses into the USART TX FIFO, and never writes while `tx_full` is asserted. It sits directly in front of `usart`: `tx_data` → `tx_data_in`, `tx_write_en` → `tx_write_en`, and `tx_full` ← `tx_full`.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `DATA_WIDTH`, 8: byte width; must match the USART.
- `MAX_BURST`, 16: maximum bytes per grant when packet lock is compiled in, ≥1.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  requester i has a byte.
- `req_data`  in  N_REQ*DATA_WIDTH  requester i byte at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_last`  in  N_REQ  byte offered by requester i ends its packet.
- `req_ready`  out  N_REQ  one-hot or zero; combinational.
- `tx_data`  out  DATA_WIDTH  registered byte to the USART TX FIFO.
- `tx_write_en`  out  1  registered one-cycle write strobe.
- `tx_full`  in  1  USART TX FIFO full.
- `grant_id`  out  $clog2(N_REQ)  current or last owner.
- `busy`  out  1  high in GRANT.

## Operation
- States: IDLE, GRANT. Registers: `state`, `grant_id`, `rr_ptr` (last served), `burst_cnt` ($clog2(MAX_BURST+1) bits), `tx_data`, `tx_write_en`.
- IDLE behaviour:
  - If any `req_valid` is set, select the first set index searching `rr_ptr+1`, `rr_ptr+2`, … modulo N_REQ.
  - Load `grant_id` with that index, clear `burst_cnt`, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT behaviour:
  - `req_ready[grant_id] = !tx_full && !tx_write_en`. All other ready bits are 0. `req_ready` is all zeros in IDLE.
  - Accept = `req_valid[grant_id] && req_ready[grant_id]`.
  - On accept, the next cycle drives `tx_data` = that byte and `tx_write_en` = 1. `burst_cnt` increments.
- Release from GRANT sets `rr_ptr <= grant_id` and moves to IDLE. The release rule depends on `USART_ARB_PKT_LOCK_EN` (see Configuration).
- If the granted requester drops `req_valid` while in GRANT, the arbiter keeps the grant and waits. No timeout.
- `grant_id` holds its value in IDLE.
- Reset (asynchronous, any time): `state`=IDLE, `rr_ptr`=N_REQ-1 (requester 0 has first priority), `grant_id`=0, `burst_cnt`=0, `tx_data`=0, `tx_write_en`=0, `busy`=0, `req_ready`=0. A byte accepted but not yet written is discarded.

## Timing
- Arbitration latency: 1 cycle. A request seen in IDLE at edge t gives GRANT, and ready can be high, during cycle t+1.
- Accept-to-write latency: 1 cycle. The FIFO captures the byte at the edge that ends the `tx_write_en` cycle.
- Throughput: at most 1 byte per 2 cycles. Ready is masked while `tx_write_en` is high, so a byte can never be written into a FIFO that filled on the previous write.
- `tx_full` high: no accept and no write. The state is otherwise frozen.
- Simultaneous requests: resolved only in IDLE, by strict rotation from `rr_ptr`. Requests arriving during GRANT wait.

## Configuration
- `USART_ARB_PKT_LOCK_EN` defined:
  - The grant is held for the whole packet.
  - Release happens on an accept with `req_last` set, or on the accept that makes `burst_cnt` == MAX_BURST, whichever comes first.
- `USART_ARB_PKT_LOCK_EN` undefined:
  - Release happens after every accepted byte, giving per-byte round-robin.
  - `req_last` and `MAX_BURST` are ignored, and `burst_cnt` is optimized away.

## Test plan
- Only req0 is valid with 0xA5: GRANT 1 cycle later, `req_ready[0]` high, then `tx_write_en` for 1 cycle with `tx_data`=0xA5. `busy` returns to 0.
- Lock undefined, all 4 requesters continuously valid with bytes 0x10/0x20/0x30/0x40: FIFO receives 0x10, 0x20, 0x30, 0x40, 0x10, …
- `tx_full` forced high for 10 cycles while req2 is valid: `req_ready` stays 0 and there is no `tx_write_en`. After release, 0x77 is written exactly once.
- Lock defined, req1 sends 0x11, 0x22, 0x33 (last) while req2 holds 0x99: FIFO order is 0x11, 0x22, 0x33, 0x99.
- Lock defined with MAX_BURST=4, req0 sends 6 bytes with no last, req3 valid: req0 byte 4 is followed by a req3 byte, then req0 resumes.
- `rst_n` pulsed low mid-packet during a `tx_write_en` cycle: all outputs go 0 immediately. After reset, req0 wins first even if req2 is also requesting.
